score_keeper: RTL and testbench

SCORE_KEEPER -- requirements
Module: score_keeper

---
 rtl/score_keeper.sv | 116 +++++++++++
 tb/tb_score_keeper.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/score_keeper.sv
// Purpose : rhythm-game score keeper; scores graded hits, tracks combo/max combo and a combo multiplier.
// Latency : one cycle; an event sampled on a rising edge shows on the registered outputs right after that edge.
// Backpress: none; hit/miss are single-cycle strobes, always absorbed when enable=1 (ignored when enable=0).
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset (dominates everything)
//   enable, clear       game running / synchronous restart (clear works regardless of enable)
//   hit, hit_grade      note-hit strobe and its grade (11=50, 10=20, 0x=10 base points)
//   miss                note-miss strobe; wins over a simultaneous hit
//   score               saturating score (ceiling SCORE_MAX)
//   combo, max_combo    consecutive hits and their high-water mark (ceiling COMBO_MAX)
//   multiplier          1..4 point multiplier derived from combo
//   score_changed       one-cycle pulse when score takes a new value
//   saturated, conflict sticky flags: score hit ceiling / hit+miss seen together
//
// Build option: define SCORE_KEEPER_MULT_EN to enable the combo multiplier;
// without it the multiplier stays at 1 and points equal the base grade value.

module score_keeper #(
    parameter int SCORE_MAX = 9999,
    parameter int COMBO_MAX = 65535
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        clear,
    input  logic        hit,
    input  logic [1:0]  hit_grade,
    input  logic        miss,
    output logic [31:0] score,
    output logic [15:0] combo,
    output logic [15:0] max_combo,
    output logic [2:0]  multiplier,
    output logic        score_changed,
    output logic        saturated,
    output logic        conflict
);

    localparam logic [34:0] SCORE_CAP_W = 35'(SCORE_MAX);
    localparam logic [31:0] SCORE_CAP   = 32'(SCORE_MAX);
    localparam logic [15:0] COMBO_CAP   = 16'(COMBO_MAX);

    logic [5:0]  base_pts;
    logic [34:0] points;
    logic [34:0] sum;
    logic        sum_at_cap;
    logic [31:0] score_hit;
    logic [15:0] combo_hit;
    logic [2:0]  mult_hit;

    always_comb begin
        base_pts = 6'd10;
        case (hit_grade)
            2'b11:   base_pts = 6'd50;
            2'b10:   base_pts = 6'd20;
            default: base_pts = 6'd10;
        endcase
    end

    // Product and sum carried at 35 bits so the saturation compare sees the true value.
    assign points     = 35'(base_pts) * 35'(multiplier);
    assign sum        = {3'b000, score} + points;
    assign sum_at_cap = (sum >= SCORE_CAP_W);
    assign score_hit  = sum_at_cap ? SCORE_CAP : sum[31:0];
    assign combo_hit  = (combo >= COMBO_CAP) ? combo : combo + 16'd1;

`ifdef SCORE_KEEPER_MULT_EN
    // Multiplier follows the post-hit combo, so it steps up on the same edge as combo.
    always_comb begin
        if (combo_hit < 16'd10)      mult_hit = 3'd1;
        else if (combo_hit < 16'd20) mult_hit = 3'd2;
        else if (combo_hit < 16'd30) mult_hit = 3'd3;
        else                         mult_hit = 3'd4;
    end
`else
    assign mult_hit = 3'd1;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            score         <= 32'd0;
            combo         <= 16'd0;
            max_combo     <= 16'd0;
            multiplier    <= 3'd1;
            score_changed <= 1'b0;
            saturated     <= 1'b0;
            conflict      <= 1'b0;
        end else if (clear) begin
            // Restart keeps max_combo as the session high-water mark.
            score         <= 32'd0;
            combo         <= 16'd0;
            multiplier    <= 3'd1;
            saturated     <= 1'b0;
            conflict      <= 1'b0;
            score_changed <= (score != 32'd0);
        end else if (enable) begin
            score_changed <= 1'b0;
            if (miss) begin
                // Miss wins over a same-cycle hit; the hit is dropped and flagged.
                combo      <= 16'd0;
                multiplier <= 3'd1;
                if (hit) conflict <= 1'b1;
            end else if (hit) begin
                score         <= score_hit;
                score_changed <= (score_hit != score);
                if (sum_at_cap) saturated <= 1'b1;
                combo      <= combo_hit;
                multiplier <= mult_hit;
                if (combo_hit > max_combo) max_combo <= combo_hit;
            end
        end else begin
            score_changed <= 1'b0;
        end
    end

endmodule

// File: tb/tb_score_keeper.sv
module tb_score_keeper;

    localparam int SMAX = 9999;
    localparam int CMAX = 40;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        clear = 1'b0;
    logic        hit = 1'b0;
    logic [1:0]  hit_grade = 2'b00;
    logic        miss = 1'b0;
    logic [31:0] score;
    logic [15:0] combo;
    logic [15:0] max_combo;
    logic [2:0]  multiplier;
    logic        score_changed;
    logic        saturated;
    logic        conflict;

    score_keeper #(.SCORE_MAX(SMAX), .COMBO_MAX(CMAX)) dut (
        .clock(clock), .reset(reset), .enable(enable), .clear(clear),
        .hit(hit), .hit_grade(hit_grade), .miss(miss),
        .score(score), .combo(combo), .max_combo(max_combo),
        .multiplier(multiplier), .score_changed(score_changed),
        .saturated(saturated), .conflict(conflict)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    logic [70:0] sb[$];
    logic [70:0] e;

    // Behavioural reference state
    int       m_score, m_combo, m_max, m_mult;
    logic     m_chg, m_sat, m_conf;

    function automatic logic [70:0] outs();
        return {score, combo, max_combo, multiplier, score_changed, saturated, conflict};
    endfunction

    function automatic int mult_of(int c);
`ifdef SCORE_KEEPER_MULT_EN
        if (c < 10) return 1;
        if (c < 20) return 2;
        if (c < 30) return 3;
        return 4;
`else
        return (c >= 0) ? 1 : 1;
`endif
    endfunction

    function automatic int base_of(logic [1:0] g);
        if (g == 2'b11) return 50;
        if (g == 2'b10) return 20;
        return 10;
    endfunction

    task automatic model(input logic h, input logic [1:0] g, input logic m,
                         input logic en, input logic c, input logic r);
        int ns;
        if (r) begin
            m_score = 0; m_combo = 0; m_max = 0; m_mult = 1;
            m_chg = 0; m_sat = 0; m_conf = 0;
        end else if (c) begin
            m_chg = (m_score != 0);
            m_score = 0; m_combo = 0; m_mult = 1; m_sat = 0; m_conf = 0;
        end else if (en) begin
            m_chg = 0;
            if (m) begin
                if (h) m_conf = 1;
                m_combo = 0; m_mult = 1;
            end else if (h) begin
                ns = m_score + base_of(g) * m_mult;
                if (ns >= SMAX) begin ns = SMAX; m_sat = 1; end
                m_chg = (ns != m_score);
                m_score = ns;
                if (m_combo < CMAX) m_combo = m_combo + 1;
                if (m_combo > m_max) m_max = m_combo;
                m_mult = mult_of(m_combo);
            end
        end else begin
            m_chg = 0;
        end
    endtask

    // Drive one cycle of stimulus, advance the model and queue the expected outputs.
    task automatic step(input logic h, input logic [1:0] g, input logic m,
                        input logic en, input logic c, input logic r);
        hit = h; hit_grade = g; miss = m; enable = en; clear = c; reset = r;
        @(posedge clock);
        model(h, g, m, en, c, r);
        sb.push_back({m_score[31:0], m_combo[15:0], m_max[15:0], m_mult[2:0], m_chg, m_sat, m_conf});
        #1;
    endtask

    task automatic test_reset();
        step(1, 2'b11, 0, 1, 0, 1);
        step(0, 2'b00, 0, 0, 0, 1);
        for (int i = 0; i < 2; i++) begin
            e = sb.pop_front(); checks++;
            if (i == 1 && outs() !== e) begin errors++; $display("FAIL reset_model got %h want %h", outs(), e); end
        end
        checks++;
        if (outs() !== {32'd0, 16'd0, 16'd0, 3'd1, 3'b000}) begin
            errors++; $display("FAIL reset_values got %h want %h", outs(), {32'd0, 16'd0, 16'd0, 3'd1, 3'b000});
        end
    endtask

    task automatic test_basic();
        int pulses = 0;
        step(0, 2'b00, 0, 0, 0, 1); e = sb.pop_front();
        for (int i = 0; i < 3; i++) begin
            step(1, 2'b11, 0, 1, 0, 0);
            e = sb.pop_front(); checks++;
            if (outs() !== e) begin errors++; $display("FAIL basic_hit%0d got %h want %h", i, outs(), e); end
            if (score_changed) pulses++;
        end
        checks++;
        if (score !== 32'd150 || combo !== 16'd3 || multiplier !== 3'd1 || pulses != 3) begin
            errors++; $display("FAIL basic_totals got score=%0d combo=%0d mult=%0d pulses=%0d want 150 3 1 3",
                               score, combo, multiplier, pulses);
        end
    endtask

    task automatic test_multiplier();
        step(0, 2'b00, 0, 0, 0, 1); e = sb.pop_front();
        for (int i = 1; i <= 11; i++) begin
            step(1, 2'b01, 0, 1, 0, 0);
            e = sb.pop_front(); checks++;
            if (outs() !== e) begin errors++; $display("FAIL mult_hit%0d got %h want %h", i, outs(), e); end
            if (i == 10) begin
                checks++;
`ifdef SCORE_KEEPER_MULT_EN
                if (combo !== 16'd10 || multiplier !== 3'd2) begin
                    errors++; $display("FAIL mult_step got combo=%0d mult=%0d want 10 2", combo, multiplier);
                end
`else
                if (combo !== 16'd10 || multiplier !== 3'd1) begin
                    errors++; $display("FAIL mult_step got combo=%0d mult=%0d want 10 1", combo, multiplier);
                end
`endif
            end
        end
        checks++;
`ifdef SCORE_KEEPER_MULT_EN
        if (score !== 32'd120) begin errors++; $display("FAIL mult_score got %0d want 120", score); end
`else
        if (score !== 32'd110) begin errors++; $display("FAIL mult_score got %0d want 110", score); end
`endif
    endtask

    task automatic test_miss();
        step(0, 2'b00, 0, 0, 0, 1); e = sb.pop_front();
        for (int i = 0; i < 12; i++) begin
            step(1, 2'b00, 0, 1, 0, 0);
            e = sb.pop_front(); checks++;
            if (outs() !== e) begin errors++; $display("FAIL miss_pre%0d got %h want %h", i, outs(), e); end
        end
        step(0, 2'b00, 1, 1, 0, 0);
        e = sb.pop_front(); checks++;
        if (outs() !== e) begin errors++; $display("FAIL miss_model got %h want %h", outs(), e); end
        checks++;
`ifdef SCORE_KEEPER_MULT_EN
        if (score !== 32'd140 || combo !== 16'd0 || multiplier !== 3'd1 || max_combo !== 16'd12 || score_changed !== 1'b0) begin
            errors++; $display("FAIL miss_state got score=%0d combo=%0d mult=%0d max=%0d chg=%b want 140 0 1 12 0",
                               score, combo, multiplier, max_combo, score_changed);
        end
`else
        if (score !== 32'd120 || combo !== 16'd0 || multiplier !== 3'd1 || max_combo !== 16'd12 || score_changed !== 1'b0) begin
            errors++; $display("FAIL miss_state got score=%0d combo=%0d mult=%0d max=%0d chg=%b want 120 0 1 12 0",
                               score, combo, multiplier, max_combo, score_changed);
        end
`endif
    endtask

    task automatic test_combo_levels();
        step(0, 2'b00, 0, 0, 0, 1); e = sb.pop_front();
        for (int i = 1; i <= 45; i++) begin
            step(1, 2'b01, 0, 1, 0, 0);
            e = sb.pop_front(); checks++;
            if (outs() !== e) begin errors++; $display("FAIL levels_hit%0d got %h want %h", i, outs(), e); end
            if (i == 31) begin
                checks++;
`ifdef SCORE_KEEPER_MULT_EN
                if (multiplier !== 3'd4) begin errors++; $display("FAIL levels_x4 got %0d want 4", multiplier); end
`else
                if (multiplier !== 3'd1) begin errors++; $display("FAIL levels_x4 got %0d want 1", multiplier); end
`endif
            end
        end
        checks++;
        if (combo !== 16'(CMAX) || max_combo !== 16'(CMAX)) begin
            errors++; $display("FAIL combo_cap got combo=%0d max=%0d want %0d", combo, max_combo, CMAX);
        end
    endtask

    task automatic test_saturation();
        step(0, 2'b00, 0, 0, 0, 1); e = sb.pop_front();
        for (int i = 0; i < 203; i++) begin
            if (m_combo >= 9) begin
                step(0, 2'b00, 1, 1, 0, 0);
                e = sb.pop_front(); checks++;
                if (outs() !== e) begin errors++; $display("FAIL sat_miss%0d got %h want %h", i, outs(), e); end
            end
            step(1, (i < 199) ? 2'b11 : 2'b01, 0, 1, 0, 0);
            e = sb.pop_front(); checks++;
            if (outs() !== e) begin errors++; $display("FAIL sat_fill%0d got %h want %h", i, outs(), e); end
        end
        if (m_combo >= 9) begin
            step(0, 2'b00, 1, 1, 0, 0); e = sb.pop_front();
        end
        checks++;
        if (score !== 32'd9990 || multiplier !== 3'd1 || saturated !== 1'b0) begin
            errors++; $display("FAIL sat_pre got score=%0d mult=%0d sat=%b want 9990 1 0", score, multiplier, saturated);
        end
        step(1, 2'b11, 0, 1, 0, 0);
        e = sb.pop_front(); checks++;
        if (score !== 32'd9999 || saturated !== 1'b1 || score_changed !== 1'b1 || outs() !== e) begin
            errors++; $display("FAIL sat_hit got %h want %h", outs(), e);
        end
        step(1, 2'b11, 0, 1, 0, 0);
        e = sb.pop_front(); checks++;
        if (score !== 32'd9999 || score_changed !== 1'b0 || saturated !== 1'b1 || outs() !== e) begin
            errors++; $display("FAIL sat_hold got %h want %h", outs(), e);
        end
    endtask

    task automatic test_conflict();
        step(0, 2'b00, 0, 0, 0, 1); e = sb.pop_front();
        step(1, 2'b11, 0, 1, 0, 0); e = sb.pop_front();
        step(1, 2'b11, 0, 1, 0, 0); e = sb.pop_front();
        step(1, 2'b11, 1, 1, 0, 0);
        e = sb.pop_front(); checks++;
        if (combo !== 16'd0 || score !== 32'd100 || conflict !== 1'b1 || outs() !== e) begin
            errors++; $display("FAIL conflict_set got %h want %h", outs(), e);
        end
        step(0, 2'b00, 0, 1, 1, 0);
        e = sb.pop_front(); checks++;
        if (conflict !== 1'b0 || score !== 32'd0 || max_combo !== 16'd2 || score_changed !== 1'b1 || outs() !== e) begin
            errors++; $display("FAIL conflict_clear got %h want %h", outs(), e);
        end
    endtask

    task automatic test_enable_and_priority();
        step(0, 2'b00, 0, 0, 0, 1); e = sb.pop_front();
        step(1, 2'b10, 0, 1, 0, 0); e = sb.pop_front();
        for (int i = 0; i < 5; i++) begin
            step(1, 2'b11, 0, 0, 0, 0);
            e = sb.pop_front(); checks++;
            if (score !== 32'd20 || combo !== 16'd1 || score_changed !== 1'b0 || outs() !== e) begin
                errors++; $display("FAIL enable_hold%0d got %h want %h", i, outs(), e);
            end
        end
        // clear beats a simultaneous hit, even with enable low
        step(1, 2'b11, 0, 0, 1, 0);
        e = sb.pop_front(); checks++;
        if (score !== 32'd0 || combo !== 16'd0 || score_changed !== 1'b1 || max_combo !== 16'd1 || outs() !== e) begin
            errors++; $display("FAIL clear_prio got %h want %h", outs(), e);
        end
        step(1, 2'b11, 0, 1, 0, 0); e = sb.pop_front();
        step(1, 2'b11, 0, 1, 0, 0); e = sb.pop_front();
        step(1, 2'b11, 1, 1, 1, 1);
        e = sb.pop_front(); checks++;
        if (outs() !== {32'd0, 16'd0, 16'd0, 3'd1, 3'b000} || outs() !== e) begin
            errors++; $display("FAIL reset_dominates got %h want %h", outs(), {32'd0, 16'd0, 16'd0, 3'd1, 3'b000});
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_multiplier();
        test_miss();
        test_combo_levels();
        test_saturation();
        test_conflict();
        test_enable_and_priority();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
